div_issue_ctrl: RTL and testbench

- Upstream control stage for the multi-cycle 32-bit unsigned Divider in the RV32M execute path.
- Accepts DIV/DIVU/REM/REMU requests from EX and resolves divide-by-zero and signed-overflow locally.
- Otherwise drives magnitude operands into the Divider, waits its fixed latency, sign-corrects the quotient or remainder, and returns one result with a done pulse.

---
 rtl/div_issue_ctrl_if.sv | 32 +++
 rtl/div_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// Handshake and Divider bus for the RV32M divide issue controller.
// slave: the controller; master: EX stage plus Divider side.
interface div_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;

  modport slave (
    input  start, op, rs1, rs2, flush,
    input  div_quotient, div_remainder,
    output busy, done, result,
    output div_dividend, div_divisor
  );

  modport master (
    output start, op, rs1, rs2, flush,
    output div_quotient, div_remainder,
    input  busy, done, result,
    input  div_dividend, div_divisor
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// RV32M divide issue control: special cases, magnitude
// operands to the Divider, fixed wait and sign correction.
module div_issue_ctrl #(
  parameter int DIV_LATENCY = 4,
  parameter int XLEN        = 32
) (
  input logic             clk,
  input logic             rst,
  div_issue_ctrl_if.slave bus
);
  localparam int CW =
    (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DIV_LATENCY - 1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            rem_q, rem_d;
  logic            na_q, na_d;
  logic            nb_q, nb_d;
  logic            busy_q, done_q;

  logic            sgn_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            by_zero, ovf;
  logic [XLEN-1:0] spec_res;
  logic [XLEN-1:0] q_fix, r_fix, cap;

  // Request decode: magnitudes and early-out results
  always_comb begin
    sgn_op  = ~bus.op[0];
    a_neg   = sgn_op & bus.rs1[XLEN-1];
    b_neg   = sgn_op & bus.rs2[XLEN-1];
    a_mag   = a_neg ? -bus.rs1 : bus.rs1;
    b_mag   = b_neg ? -bus.rs2 : bus.rs2;
    by_zero = (bus.rs2 == '0);
    ovf     = sgn_op & (bus.rs1 == MIN_NEG)
            & (bus.rs2 == '1);
    spec_res = '0;
    unique case (1'b1)
      by_zero: spec_res = bus.op[1] ? bus.rs1 : '1;
      ovf:     spec_res = bus.op[1] ? '0 : MIN_NEG;
      default: spec_res = '0;
    endcase
  end

  // Sign correction of the Divider's unsigned outputs
  always_comb begin
    q_fix = (na_q ^ nb_q) ? -bus.div_quotient
                          : bus.div_quotient;
    r_fix = na_q ? -bus.div_remainder
                 : bus.div_remainder;
    cap   = rem_q ? r_fix : q_fix;
  end

  // Next state: accept, wait count, capture, flush abort
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    na_d    = na_q;
    nb_d    = nb_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          res_d   = cap;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start) begin
          rem_d = bus.op[1];
          na_d  = a_neg;
          nb_d  = b_neg;
          if (by_zero || ovf) begin
            state_d = S_DONE;
            res_d   = spec_res;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
          end
        end
      end
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      na_d    = na_q;
      nb_d    = nb_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= 1'b0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      busy_q  <= (state_d == S_WAIT);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = res_q;
  assign bus.div_dividend = dvd_q;
  assign bus.div_divisor  = dvs_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: vector table, corner
// sequences and random ops against a signed-math model.
module tb_div_issue_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_issue_ctrl_if #(.XLEN(32)) ifc ();

  div_issue_ctrl #(
    .DIV_LATENCY(LAT),
    .XLEN(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  // Ideal unsigned Divider; controller waits LAT edges
  assign ifc.div_quotient = (ifc.div_divisor == '0)
    ? '1 : ifc.div_dividend / ifc.div_divisor;
  assign ifc.div_remainder = (ifc.div_divisor == '0)
    ? ifc.div_dividend
    : ifc.div_dividend % ifc.div_divisor;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  // RISC-V M-extension semantics, in plain signed math
  function automatic logic [31:0] model(
    input logic [1:0] o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'd0: return 32'(sa / sb);
      2'd1: return a / b;
      2'd2: return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(
    input logic [1:0] o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (b == 0) return 0;
    if (!o[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 0;
    return LAT;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  // Called at a negedge; lat counts edges until done seen
  task automatic wait_done(
    output logic [31:0] r,
    output int lat,
    output int nb
  );
    lat = 0;
    nb  = 0;
    r   = '0;
    while (!ifc.done && lat < 40) begin
      if (ifc.busy) nb++;
      @(negedge clk);
      lat++;
    end
    if (ifc.done) begin
      r = ifc.result;
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done after %0d edges",
               lat);
    end
  endtask

  task automatic drive(
    input logic [1:0] o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op    = o;
    ifc.rs1   = a;
    ifc.rs2   = b;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.op    = 2'($urandom);
    ifc.rs1   = $urandom;
    ifc.rs2   = $urandom;
  endtask

  task automatic do_op(
    input string nm,
    input logic [1:0] o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] er,
    input int el
  );
    logic [31:0] r;
    int lat, nb;
    drive(o, a, b);
    wait_done(r, lat, nb);
    chk({nm, "_res"}, r, er);
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    chk({nm, "_busy"}, 32'(nb), 32'(el));
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(ifc.done), 32'd0);
  endtask

  task automatic no_done(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (ifc.done) seen++;
      @(negedge clk);
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] r, prior;
    int lat, nb;
    logic [1:0]  o;
    logic [31:0] a, b;

    tbl[0]  = '{2'd0, 32'h14, 32'hFFFF_FFFD,
                32'hFFFF_FFFA, LAT};
    tbl[1]  = '{2'd2, 32'hFFFF_FFEC, 32'h3,
                32'hFFFF_FFFE, LAT};
    tbl[2]  = '{2'd2, 32'h14, 32'hFFFF_FFFD,
                32'h2, LAT};
    tbl[3]  = '{2'd1, 32'hFFFF_FFFF, 32'h10,
                32'h0FFF_FFFF, LAT};
    tbl[4]  = '{2'd3, 32'hFFFF_FFFF, 32'h10,
                32'hF, LAT};
    tbl[5]  = '{2'd0, 32'h7, 32'h0,
                32'hFFFF_FFFF, 0};
    tbl[6]  = '{2'd3, 32'h7, 32'h0, 32'h7, 0};
    tbl[7]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 0};
    tbl[8]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0, 0};
    tbl[9]  = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0, LAT};
    tbl[10] = '{2'd0, 32'h8000_0000, 32'h1,
                32'h8000_0000, LAT};
    tbl[11] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
                32'hFFFF_FFFF, LAT};
    tbl[12] = '{2'd1, 32'h64, 32'h7, 32'hE, LAT};

    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    ifc.op    = '0;
    ifc.rs1   = '0;
    ifc.rs2   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_result", ifc.result, 32'd0);
    chk("rst_dvd", ifc.div_dividend, 32'd0);
    chk("rst_dvs", ifc.div_divisor, 32'd0);

    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].op,
            tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    // Divider operands, and start ignored while busy
    drive(2'd0, 32'h14, 32'hFFFF_FFFD);
    chk("dvd_mag", ifc.div_dividend, 32'd20);
    chk("dvs_mag", ifc.div_divisor, 32'd3);
    ifc.start = 1'b1;
    ifc.op    = 2'd1;
    ifc.rs1   = 32'd100;
    ifc.rs2   = 32'd7;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("dvd_hold", ifc.div_dividend, 32'd20);
    chk("dvs_hold", ifc.div_divisor, 32'd3);
    wait_done(r, lat, nb);
    chk("ign_res", r, 32'hFFFF_FFFA);
    chk("ign_lat", 32'(lat), 32'(LAT - 1));
    @(negedge clk);
    no_done("ign_nodone", 6);
    chk("idle_dvd", ifc.div_dividend, 32'd20);

    // Flush two cycles into WAIT
    prior = ifc.result;
    drive(2'd3, 32'd1000, 32'd9);
    @(negedge clk);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    chk("fl_busy", 32'(ifc.busy), 32'd0);
    chk("fl_done", 32'(ifc.done), 32'd0);
    chk("fl_result", ifc.result, prior);
    no_done("fl_nodone", 8);
    chk("fl_keep", ifc.result, prior);
    do_op("fl_next", 2'd1, 32'd100, 32'd7, 32'd14, LAT);

    // Flush together with start drops the request
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.flush = 1'b1;
    ifc.op    = 2'd0;
    ifc.rs1   = 32'd5;
    ifc.rs2   = 32'd0;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    chk("fs_busy", 32'(ifc.busy), 32'd0);
    no_done("fs_nodone", 6);
    chk("fs_result", ifc.result, 32'd14);

    // Reset mid-WAIT
    drive(2'd0, 32'h14, 32'hFFFF_FFFD);
    @(negedge clk);
    rst = 1'b1;
    ifc.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifc.start = 1'b0;
    chk("mr_busy", 32'(ifc.busy), 32'd0);
    chk("mr_done", 32'(ifc.done), 32'd0);
    chk("mr_result", ifc.result, 32'd0);
    chk("mr_dvd", ifc.div_dividend, 32'd0);
    chk("mr_dvs", ifc.div_divisor, 32'd0);
    no_done("mr_nodone", 8);

    // Back-to-back: start held during DONE
    drive(2'd0, 32'h14, 32'hFFFF_FFFD);
    wait_done(r, lat, nb);
    chk("b2b_a_res", r, 32'hFFFF_FFFA);
    ifc.start = 1'b1;
    ifc.op    = 2'd3;
    ifc.rs1   = 32'hFFFF_FFFF;
    ifc.rs2   = 32'h10;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("b2b_busy", 32'(ifc.busy), 32'd1);
    wait_done(r, lat, nb);
    chk("b2b_b_res", r, 32'hF);
    chk("b2b_b_lat", 32'(lat), 32'(LAT));

    // Back-to-back into a special case
    ifc.start = 1'b1;
    ifc.op    = 2'd1;
    ifc.rs1   = 32'd9;
    ifc.rs2   = 32'd0;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("b2b_c_done", 32'(ifc.done), 32'd1);
    chk("b2b_c_res", ifc.result, 32'hFFFF_FFFF);

    // Random operations against the model
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        4: a = 32'h8000_0000;
        default: ;
      endcase
      do_op($sformatf("rnd%0d", i), o, a, b,
            model(o, a, b), model_lat(o, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
